serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and difference width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  operand pair a/b presented.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  minuend, unsigned.
REQ-007 b  input  WIDTH  subtrahend, unsigned.
REQ-008 out_valid  output  1  Difference/Borrow hold a completed result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 Difference  output  WIDTH  (a - b) mod 2^WIDTH.
REQ-011 Borrow  output  1  1 when a < b (unsigned), else 0.

Function
REQ-012 The block SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE: in_ready=1 and out_valid=0; an in_valid=1 edge SHALL latch a and b into shift registers, clear the borrow flop and the bit counter, and go to SHIFT.
REQ-014 SHIFT: in_ready=0 and out_valid=0; each edge SHALL pass bit 0 of a, bit 0 of b and the borrow flop through one full-subtractor cell.
REQ-015 Per bit: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin); d SHALL shift into the MSB of the difference register (LSB-first, right shift), and bout SHALL load the borrow flop.
REQ-016 The counter SHALL count 0..WIDTH-1; on the edge that processes bit WIDTH-1 the FSM SHALL go to DONE.
REQ-017 Latency: out_valid SHALL rise exactly WIDTH clock cycles after the edge that accepted the operands.
REQ-018 DONE: out_valid=1, in_ready=0; Difference and Borrow SHALL hold stable until an edge with out_ready=1, which SHALL return the FSM to IDLE.
REQ-019 in_valid while in SHIFT or DONE SHALL be ignored, with no latching and no effect on the computation in progress.
REQ-020 Difference and Borrow SHALL be driven straight from registers; outside DONE their value is don't-care to the consumer but SHALL NOT glitch combinationally.
REQ-021 No new acceptance in the cycle DONE exits; the minimum issue interval is WIDTH+2 cycles.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, with counter=0, borrow flop=0 and the difference register=0, so Difference=0, Borrow=0, in_ready=1 and out_valid=0 in the next cycle.
REQ-023 Reset SHALL take priority over every other event, including reset during SHIFT or DONE; the partial result is discarded and no out_valid follows.
REQ-024 in_valid coincident with rst SHALL be ignored.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-026 The 1-bit cell SHALL be the combinational sub-module full_subtractor (inputs a, b, bin; outputs d, bout), instantiated once.
REQ-027 The counter width SHALL be $clog2(WIDTH), and no arithmetic wider than 1 bit SHALL appear outside the counter.

Verification (WIDTH=8)
REQ-028 Accept a=0x05, b=0x03 with out_ready=1 -> out_valid 8 cycles later with Difference=0x02, Borrow=0.
REQ-029 a=0x03, b=0x05 -> Difference=0xFE, Borrow=1; a=0x00, b=0xFF -> Difference=0x01, Borrow=1; a=b=0x00 -> 0x00, 0.
REQ-030 Hold out_ready=0 for 5 cycles in DONE -> out_valid, Difference and Borrow stay constant; raising out_ready -> IDLE and in_ready=1 next cycle.
REQ-031 Pulse in_valid with a=0xFF, b=0x00 during SHIFT of 0x05-0x03 -> result remains 0x02, 0, and the second pair is never processed.
REQ-032 Assert rst at cycle 4 of SHIFT -> next cycle IDLE, Difference=0, Borrow=0, no out_valid; a following 0x10-0x01 -> 0x0F, 0.
REQ-033 Exhaustive sweep of all 65536 a/b pairs against a reference model of a-b with an 8-bit wrap and borrow -> zero mismatches.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: default operand width and FSM state encoding.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with the borrow out to the next bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first over WIDTH cycles through one
// full-subtractor cell, with valid/ready handshakes on both the operand and result sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Difference,
  output logic             Borrow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow_q;
  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Operands shift right so bit 0 always feeds the cell; each result bit enters at the MSB,
  // so after WIDTH shifts the difference register is aligned with bit 0 at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow_q <= 1'b0;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
          diff_sr  <= {cell_d, diff_sr[WIDTH-1:1]};
          borrow_q <= cell_bout;
          cnt      <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign Difference = diff_sr;
  assign Borrow     = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8, plus a strided/random sweep
// against an arithmetic reference of a - b with 8-bit wrap and borrow.
module tb_serial_subtractor;

  localparam int LIMIT = 20;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] difference;
  logic       borrow;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Difference (difference),
    .Borrow     (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic accept(input logic [7:0] av, input logic [7:0] bv);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    step();
    in_valid = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < LIMIT) begin
      step();
      cycles++;
    end
  endtask

  // One full transaction with out_ready held high: latency, result, and return to IDLE.
  task automatic applyStimulus(input string tag, input logic [7:0] av, input logic [7:0] bv,
                               input logic [7:0] expd, input logic expb);
    int cycles;
    checkOutput({tag, "_ready_before"}, 32'(in_ready), 32'd1);
    accept(av, bv);
    waitDone(cycles);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd8);
    checkOutput({tag, "_diff"}, 32'(difference), 32'(expd));
    checkOutput({tag, "_borrow"}, 32'(borrow), 32'(expb));
    step();
    checkOutput({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  task automatic sweepOne(input logic [7:0] av, input logic [7:0] bv);
    int cycles;
    logic [8:0] ref9;
    ref9 = {1'b0, av} - {1'b0, bv};
    accept(av, bv);
    waitDone(cycles);
    checkOutput($sformatf("sweep_%02h_%02h", av, bv), {23'd0, borrow, difference}, {23'd0, ref9});
    step();
  endtask

  initial begin
    int cycles;
    int pre;
    logic quiet;
    logic [7:0] hd;
    logic       hb;

    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 8'hAA;
    b         = 8'h55;
    out_ready = 1'b1;

    // Reset with a coincident in_valid: nothing may be latched.
    step();
    step();
    checkOutput("reset_diff", 32'(difference), 32'h00);
    checkOutput("reset_borrow", 32'(borrow), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    checkOutput("post_reset_idle", 32'(in_ready), 32'd1);
    checkOutput("post_reset_no_valid", 32'(out_valid), 32'd0);

    applyStimulus("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0);
    applyStimulus("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1);
    applyStimulus("sub_00_ff", 8'h00, 8'hFF, 8'h01, 1'b1);
    applyStimulus("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0);
    applyStimulus("sub_ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0);
    applyStimulus("sub_ff_00", 8'hFF, 8'h00, 8'hFF, 1'b0);

    // Hold the result in DONE with out_ready low; an in_valid pulse there must be ignored.
    out_ready = 1'b0;
    accept(8'h80, 8'h81);
    waitDone(cycles);
    checkOutput("hold_latency", 32'(cycles), 32'd8);
    checkOutput("hold_diff", 32'(difference), 32'hFF);
    checkOutput("hold_borrow", 32'(borrow), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'h00;
      end
      if (k == 3) in_valid = 1'b0;
      step();
      checkOutput($sformatf("hold%0d_out_valid", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
      checkOutput($sformatf("hold%0d_diff", k), 32'(difference), 32'hFF);
      checkOutput($sformatf("hold%0d_borrow", k), 32'(borrow), 32'd1);
    end
    out_ready = 1'b1;
    step();
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);

    // in_valid pulsed mid-SHIFT must neither disturb the result nor queue a second job.
    accept(8'h05, 8'h03);
    step();
    step();
    in_valid = 1'b1;
    a        = 8'hFF;
    b        = 8'h00;
    step();
    in_valid = 1'b0;
    pre = 3;
    waitDone(cycles);
    checkOutput("midshift_latency", 32'(pre + cycles), 32'd8);
    checkOutput("midshift_diff", 32'(difference), 32'h02);
    checkOutput("midshift_borrow", 32'(borrow), 32'd0);
    step();
    quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
      step();
    end
    checkOutput("midshift_no_second_job", 32'(quiet), 32'd1);

    // Reset in the 4th SHIFT cycle discards the partial result.
    accept(8'h05, 8'h03);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_diff", 32'(difference), 32'h00);
    checkOutput("midreset_borrow", 32'(borrow), 32'd0);
    quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (out_valid !== 1'b0) quiet = 1'b0;
      step();
    end
    checkOutput("midreset_no_out_valid", 32'(quiet), 32'd1);
    applyStimulus("after_reset_10_01", 8'h10, 8'h01, 8'h0F, 1'b0);

    // Back-to-back issue at the minimum interval, result then checked against held values.
    out_ready = 1'b1;
    accept(8'h3C, 8'hC3);
    waitDone(cycles);
    hd = difference;
    hb = borrow;
    checkOutput("b2b_first", {23'd0, hb, hd}, 32'h179);
    step();
    applyStimulus("b2b_second", 8'hC3, 8'h3C, 8'h87, 1'b0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        sweepOne(8'(i * 17), 8'(j * 17));
      end
    end
    for (int i = 0; i < 8; i++) begin
      sweepOne(8'(1 << i), 8'(8'hFF >> i));
      sweepOne(8'(8'hFF >> i), 8'(1 << i));
    end
    for (int k = 0; k < 300; k++) begin
      sweepOne(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
